// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with decode handshake and misalignment halt
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] RETIRE_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  output logic [31:0] o_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misalign,
  output logic [31:0] retire_cnt
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, cnt_q, cnt_d;
  logic        mis_q, mis_d;
  // Next state: one outstanding fetch; HALT is left only through reset
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        state_d = (pc_q[1:0] != 2'b00) ? HALT : REQ;
        mis_d   = (pc_q[1:0] != 2'b00);
      end
      REQ:  state_d = imem_gnt ? WAIT : REQ;
      WAIT: if (imem_rvalid) begin
        instr_d = imem_rdata;
        state_d = HOLD;
      end
      HOLD: if (instr_ready) begin
        pc_d    = npc;
        cnt_d   = cnt_q + 32'd1;
        state_d = (npc[1:0] != 2'b00) ? HALT : REQ;
        mis_d   = (npc[1:0] != 2'b00);
      end
      default: ;
    endcase
  end
  // State registers with synchronous active-low reset; RETIRE_INIT is nonzero only to exercise wraparound
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= RETIRE_INIT;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end
  assign o_pc        = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == REQ);
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign misalign    = mis_q;
  assign retire_cnt  = cnt_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random checks of instr_fetch against a transaction-level model
module tb_instr_fetch;
  localparam logic [31:0] WRAP_INIT = 32'hFFFF_FFFE;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, instr_ready = 1'b0;
  logic [31:0] npc = '0, imem_rdata = '0;
  logic [31:0] o_pc, imem_addr, instr, retire_cnt;
  logic        imem_req, instr_valid, misalign;
  logic [31:0] w_pc, w_addr, w_instr, w_cnt;
  logic        w_req, w_valid, w_mis;
  int checks = 0, errors = 0;
  // transaction-level model: where the fetch is, not how it is encoded
  logic [31:0] m_pc, m_instr, m_cnt;
  bit m_mis, m_halt, m_started, m_waiting, m_full;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .npc(npc), .o_pc(o_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .misalign(misalign), .retire_cnt(retire_cnt)
  );
  instr_fetch #(.RETIRE_INIT(WRAP_INIT)) wrap (
    .clk(clk), .rst_n(rst_n), .npc(npc), .o_pc(w_pc), .imem_req(w_req),
    .imem_addr(w_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(w_instr), .instr_valid(w_valid),
    .instr_ready(instr_ready), .misalign(w_mis), .retire_cnt(w_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
      m_mis = 0; m_halt = 0; m_started = 0; m_waiting = 0; m_full = 0;
    end else if (m_halt) begin
    end else if (!m_started) begin
      m_started = 1;
      if (m_pc % 4 != 0) begin m_halt = 1; m_mis = 1; end
    end else if (m_full) begin
      if (instr_ready) begin
        m_pc = npc; m_cnt = m_cnt + 1; m_full = 0;
        if (npc % 4 != 0) begin m_halt = 1; m_mis = 1; end
      end
    end else if (m_waiting) begin
      if (imem_rvalid) begin m_instr = imem_rdata; m_waiting = 0; m_full = 1; end
    end else if (imem_gnt) m_waiting = 1;
  endtask

  task automatic cyc(input logic r, input logic g, input logic v, input logic [31:0] d,
                     input logic rd, input logic [31:0] n);
    bit req;
    rst_n = r; imem_gnt = g; imem_rvalid = v; imem_rdata = d; instr_ready = rd; npc = n;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    req = m_started && !m_halt && !m_waiting && !m_full;
    chk("o_pc", o_pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req", {31'b0, imem_req}, {31'b0, req});
    chk("instr", instr, m_instr);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_full});
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("retire_cnt", retire_cnt, m_cnt);
    chk("wrap_retire_cnt", w_cnt, WRAP_INIT + m_cnt);
  endtask

  initial begin
    logic [31:0] held;
    @(negedge clk);
    // basic fetch at minimum latency, two handshakes so the preloaded counter wraps
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_req", {31'b0, imem_req}, 32'd0);
    chk("reset_cnt", retire_cnt, 32'd0);
    cyc(1, 1, 0, 0, 1, 32'h4);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    cyc(1, 1, 0, 0, 1, 32'h4);
    cyc(1, 0, 1, 32'h2008_0005, 1, 32'h4);
    chk("valid_lat2", {31'b0, instr_valid}, 32'd1);
    chk("instr_first", instr, 32'h2008_0005);
    cyc(1, 0, 0, 0, 1, 32'h4);
    chk("pc_after_hs", o_pc, 32'h4);
    chk("cnt_after_hs", retire_cnt, 32'd1);
    chk("wrap_pre", w_cnt, 32'hFFFF_FFFF);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h1111_0000, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h8);
    chk("wrap_zero", w_cnt, 32'h0);
    // grant withheld: request and address steady for four cycles
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 32'h5555_5555, 1, 32'hC);
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h0);
    end
    cyc(1, 1, 1, 32'h7777_7777, 0, 0);
    chk("gnt_rvalid_same", instr, 32'h0);
    cyc(1, 0, 1, 32'hAC01_0000, 0, 0);
    chk("instr_stall", instr, 32'hAC01_0000);
    // decode back-pressure with npc and stray rvalid toggling
    for (int i = 0; i < 5; i++) begin
      cyc(1, $urandom_range(1), 1, $urandom, 0, $urandom);
      chk("bp_instr", instr, 32'hAC01_0000);
      chk("bp_pc", o_pc, 32'h0);
      chk("bp_valid", {31'b0, instr_valid}, 32'd1);
    end
    cyc(1, 0, 0, 0, 1, 32'h8);
    chk("bp_pc_after", o_pc, 32'h8);
    // misaligned npc halts until reset
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h1234_5678, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h42);
    chk("halt_mis", {31'b0, misalign}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1, $urandom, 1, 32'h10);
      chk("halt_req", {31'b0, imem_req}, 32'd0);
      chk("halt_pc", o_pc, 32'h42);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("halt_clear", {31'b0, misalign}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("restart_addr", imem_addr, 32'h0);
    // reset during WAIT, late rvalid ignored
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'hDEAD_BEEF, 0, 0);
    chk("late_rvalid", instr, 32'h0);
    chk("fresh_req", {31'b0, imem_req}, 32'd1);
    held = retire_cnt;
    // random traffic against the model
    for (int i = 0; i < 800; i++)
      cyc((i > 300) ? ($urandom_range(99) != 0) : 1'b1, $urandom_range(1), $urandom_range(1),
          $urandom, $urandom_range(1),
          ($urandom_range(39) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
    chk("random_progress", {31'b0, checks > 1000}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 npc  in  32  next PC from next_pc stage, computed from o_pc.
REQ-006 o_pc  out  32  current PC register; feeds next_pc stage.
REQ-007 imem_req  out  1  instruction memory request.
REQ-008 imem_addr  out  32  request address; equals o_pc.
REQ-009 imem_gnt  in  1  memory accepted request this cycle.
REQ-010 imem_rvalid  in  1  read data valid this cycle.
REQ-011 imem_rdata  in  32  read data.
REQ-012 instr  out  32  fetched instruction to decode.
REQ-013 instr_valid  out  1  instr holds a valid instruction.
REQ-014 instr_ready  in  1  decode consumes instr this cycle.
REQ-015 misalign  out  1  sticky error: PC[1:0] != 0.
REQ-016 retire_cnt  out  32  count of consumed instructions.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD, HALT, with imem_req = (state==REQ) and instr_valid = (state==HOLD).
REQ-018 IDLE SHALL go to REQ on the next edge, or to HALT with misalign=1 if o_pc[1:0]!=0.
REQ-019 In REQ, imem_addr SHALL equal o_pc and stay stable until imem_gnt=1; on gnt, go to WAIT.
REQ-020 In WAIT, on imem_rvalid=1 the block SHALL register instr<=imem_rdata and go to HOLD; imem_rvalid in any other state SHALL be ignored.
REQ-021 In HOLD, instr and o_pc SHALL remain stable until instr_ready=1.
REQ-022 On a HOLD handshake (instr_ready=1), the block SHALL load o_pc<=npc, increment retire_cnt, and go to REQ; if npc[1:0]!=0, it SHALL go to HALT and set misalign.
REQ-023 instr_ready SHALL be ignored outside HOLD.
REQ-024 HALT SHALL be exited only by reset; outputs SHALL hold their values and imem_req SHALL be 0.
REQ-025 Minimum latency: gnt in the first REQ cycle and rvalid in the first WAIT cycle SHALL give instr_valid two cycles after imem_req rises; peak throughput is one instruction per 3 cycles.
REQ-026 retire_cnt SHALL wrap from 32'hFFFF_FFFF to 0 without error indication.
REQ-027 o_pc SHALL change only on the HOLD handshake or reset; npc is never sampled otherwise.
REQ-028 Simultaneous imem_gnt and imem_rvalid in REQ: gnt SHALL be taken and rvalid ignored.

Reset
REQ-029 While rst_n=0 at a rising edge, the block SHALL set state=IDLE, o_pc=RESET_PC, instr=0, misalign=0, and retire_cnt=0; this forces imem_req=0 and instr_valid=0.
REQ-030 Reset asserted in WAIT or HOLD SHALL abandon the outstanding transaction, and a late imem_rvalid after reset SHALL NOT update instr.
REQ-031 imem_req SHALL first assert in the cycle after the first edge with rst_n=1; it SHALL NOT assert during reset.

Verification
REQ-032 Reset release, imem_gnt=1 immediately, imem_rvalid=1 next cycle with rdata=32'h2008_0005, instr_ready=1, npc=32'h4 -> imem_addr=0; instr_valid two cycles after imem_req; o_pc=4 after handshake; retire_cnt=1.
REQ-033 imem_gnt withheld 3 cycles, imem_rdata=32'hAC01_0000 -> imem_req and imem_addr=0 steady for 4 cycles; instr captured exactly once.
REQ-034 Decode back-pressure: instr_ready=0 for 5 cycles in HOLD, npc toggling -> instr, o_pc, and instr_valid stable; npc sampled only on the ready cycle.
REQ-035 Handshake with npc=32'h0000_0042 -> state HALT, misalign=1, imem_req=0 until reset; reset then clears misalign and restarts at RESET_PC.
REQ-036 rst_n=0 pulsed during WAIT, then imem_rvalid=1 with rdata=32'hDEAD_BEEF one cycle after reset release -> instr remains 0; fresh request to RESET_PC.
REQ-037 retire_cnt forced near wrap by running 2^32 handshakes (or RTL preload via a bench-only backdoor) -> 32'hFFFF_FFFF to 0 on the next handshake.
